// File: rtl/nios_pio_in_irq_if.sv
// ---------------------------------------------------------------------------
// nios_pio_in_irq_if
//   Avalon-MM slave bus bundle for the PIO input/interrupt block.
//
//   address    [1:0]  word address
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (driven by the slave)
//
//   Modports: master (bus host / testbench), slave (nios_pio_in_irq).
// ---------------------------------------------------------------------------
interface nios_pio_in_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_pio_in_irq.sv
// ---------------------------------------------------------------------------
// nios_pio_in_irq
//   Parallel input port with per-bit edge capture and a maskable interrupt,
//   exposed as a 4-word Avalon-MM slave.
//
//   Register map (word address):
//     0 data        RO  sampled input (din)
//     1 reserved    reads 0, writes ignored
//     2 irqmask     RW  DATA_WIDTH bits
//     3 edgecapture RO  write-1-to-clear; a new edge wins over a clear
//
//   Ports:
//     clk      sole clock, rising edge
//     reset    asynchronous, active-high
//     bus      Avalon-MM slave (nios_pio_in_irq_if.slave), readdata is
//              registered every cycle from the address mux (latency 1)
//     in_port  external inputs, asynchronous to clk
//     irq      combinational interrupt request, active-high
//
//   Parameters:
//     DATA_WIDTH 1..32   input width
//     EDGE_TYPE  0 rising, 1 falling, 2 any
//     IRQ_TYPE   0 level (din & irqmask), 1 edge (edgecapture & irqmask)
//
//   Build option:
//     NIOS_PIO_IN_SYNC_EN  defined   -> in_port passes a 2-flop synchronizer
//                          undefined -> din is in_port directly
// ---------------------------------------------------------------------------
module nios_pio_in_irq #(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_TYPE  = 0,
  parameter int IRQ_TYPE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  nios_pio_in_irq_if.slave      bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [DATA_WIDTH-1:0] din;

  // -------------------------------------------------------------------------
  // Input path. The prime flag must cover every post-reset cycle in which
  // prev/din still hold reset-flushed zeros rather than the live input,
  // otherwise a level already present at reset release looks like an edge.
  // Without the synchronizer that is one cycle; with it, the two sync
  // stages plus prev must refill, i.e. three cycles.
  // -------------------------------------------------------------------------
`ifdef NIOS_PIO_IN_SYNC_EN
  localparam int PRIME_CYCLES = 3;

  logic [DATA_WIDTH-1:0] sync1_q, sync1_d;
  logic [DATA_WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign din = sync2_q;
`else
  localparam int PRIME_CYCLES = 1;

  assign din = in_port;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PRIME_CYCLES-1:0] prime_q,    prime_d;
  logic [DATA_WIDTH-1:0]   prev_q,     prev_d;
  logic [DATA_WIDTH-1:0]   irqmask_q,  irqmask_d;
  logic [DATA_WIDTH-1:0]   edgecap_q,  edgecap_d;
  logic [31:0]             readdata_q, readdata_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] edge_hit;
  logic                  unused_wdata;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign wr_bits = bus.writedata[DATA_WIDTH-1:0];
  // Bits above DATA_WIDTH are architecturally ignored.
  assign unused_wdata = ^bus.writedata;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    // Edge detector; EDGE_TYPE is a constant, so only one branch survives.
    if (EDGE_TYPE == 0) begin
      edge_hit = din & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~din & prev_q;
    end else begin
      edge_hit = din ^ prev_q;
    end
    if (|prime_q) begin
      edge_hit = '0;
    end

    prime_d = prime_q >> 1;
    prev_d  = din;

    irqmask_d = irqmask_q;
    if (wr_en && (bus.address == ADDR_MASK)) begin
      irqmask_d = wr_bits;
    end

    // Clear first, then OR in new edges so a coincident edge survives.
    edgecap_d = edgecap_q;
    if (wr_en && (bus.address == ADDR_EDGE)) begin
      edgecap_d = edgecap_q & ~wr_bits;
    end
    edgecap_d = edgecap_d | edge_hit;

    readdata_d = '0;
    unique case (bus.address)
      ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = din;
      ADDR_RSVD: readdata_d                 = '0;
      ADDR_MASK: readdata_d[DATA_WIDTH-1:0] = irqmask_q;
      ADDR_EDGE: readdata_d[DATA_WIDTH-1:0] = edgecap_q;
      default:   readdata_d                 = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q    <= '1;
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      prime_q    <= prime_d;
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

  generate
    if (IRQ_TYPE == 0) begin : g_irq_level
      assign irq = |(din & irqmask_q);
    end else begin : g_irq_edge
      assign irq = |(edgecap_q & irqmask_q);
    end
  endgenerate

endmodule

// File: tb/tb_nios_pio_in_irq.sv
module tb_nios_pio_in_irq;

`ifdef NIOS_PIO_IN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_a = 8'hFF;
  logic [7:0] in_b = 8'h80;
  logic       irq_a, irq_b;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp;

  always #5 clk = ~clk;

  nios_pio_in_irq_if if_a();
  nios_pio_in_irq_if if_b();

  // Default build: rising edges, edge-based irq.
  nios_pio_in_irq #(.DATA_WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .in_port(in_a), .irq(irq_a)
  );

  // Any-edge capture, level-based irq.
  nios_pio_in_irq #(.DATA_WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .in_port(in_b), .irq(irq_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    if_a.chipselect = 1'b0; if_a.write_n = 1'b1; if_a.address = 2'd0; if_a.writedata = '0;
    if_b.chipselect = 1'b0; if_b.write_n = 1'b1; if_b.address = 2'd0; if_b.writedata = '0;
  endtask

  task automatic bus_write(input int sel, input logic [1:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      if_a.address = addr; if_a.chipselect = 1'b1; if_a.write_n = 1'b0; if_a.writedata = data;
    end else begin
      if_b.address = addr; if_b.chipselect = 1'b1; if_b.write_n = 1'b0; if_b.writedata = data;
    end
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input int sel, input logic [1:0] addr, output logic [31:0] data);
    if (sel == 0) begin
      if_a.address = addr; if_a.chipselect = 1'b1;
    end else begin
      if_b.address = addr; if_b.chipselect = 1'b1;
    end
    tick();
    data = (sel == 0) ? if_a.readdata : if_b.readdata;
    bus_idle();
  endtask

  // Reset state, then release with inputs already asserted: no capture.
  task automatic test_reset();
    tick(2);
    total++; if (if_a.readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata: got=%h exp=%h", if_a.readdata, 32'h0); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL rst_irq_a: got=%b exp=0", irq_a); end
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL rst_irq_b: got=%b exp=0", irq_b); end
    reset = 1'b0;
    tick(6);
    bus_write(0, 2'd2, 32'hFFFF_FFFF);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL prime_irq_a: got=%b exp=0", irq_a); end
    exp_q.push_back(32'h0); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL prime_edgecap_a: got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0); bus_read(0, 2'd1, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL reserved_read: got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0); bus_read(1, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL prime_edgecap_b: got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0000_00FF); bus_read(0, 2'd2, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL mask_readback: got=%h exp=%h", got, exp); end
  endtask

  // Data register latency and zero extension; rising bits get captured.
  task automatic test_data_read();
    in_a = 8'h00;
    tick(6);
    bus_write(0, 2'd0, 32'h0000_0055);  // ignored
    bus_write(0, 2'd1, 32'h0000_0066);  // ignored
    in_a = 8'hA5;
    if_a.address = 2'd0;
    tick(SYNC_LAT);
    exp_q.push_back(32'h0000_0000);
    exp = exp_q.pop_front();
    total++; if (if_a.readdata !== exp) begin bad++; $display("FAIL data_early: got=%h exp=%h", if_a.readdata, exp); end
    tick();
    exp_q.push_back(32'h0000_00A5);
    exp = exp_q.pop_front();
    total++; if (if_a.readdata !== exp) begin bad++; $display("FAIL data_latency: got=%h exp=%h", if_a.readdata, exp); end
    exp_q.push_back(32'h0000_00A5); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL data_edgecap: got=%h exp=%h", got, exp); end
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL data_irq: got=%b exp=1", irq_a); end
    bus_write(0, 2'd3, 32'h0000_00FF);
    exp_q.push_back(32'h0); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL w1c_all: got=%h exp=%h", got, exp); end
  endtask

  // Masked single-bit edge interrupt with exact capture latency and clear.
  task automatic test_irq_edge();
    bus_write(0, 2'd2, 32'h0000_0001);
    in_a = 8'hA4;
    tick(5);
    bus_write(0, 2'd3, 32'h0000_00FF);
    in_a = 8'hA5;
    tick(SYNC_LAT);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_early: got=%b exp=0", irq_a); end
    tick();
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL irq_set: got=%b exp=1", irq_a); end
    exp_q.push_back(32'h0000_0001); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL irq_edgecap: got=%h exp=%h", got, exp); end
    bus_write(0, 2'd3, 32'h0000_0001);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_clear: got=%b exp=0", irq_a); end
    exp_q.push_back(32'h0); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL irq_edgecap_clr: got=%h exp=%h", got, exp); end
  endtask

  // New edge on the same edge as a clear of that bit: set wins.
  task automatic test_set_wins();
    in_a = 8'hAD;  // bit3 rises
    tick(SYNC_LAT);
    bus_write(0, 2'd3, 32'h0000_0008);
    exp_q.push_back(32'h0000_0008); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL set_wins: got=%h exp=%h", got, exp); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL set_wins_unmasked_irq: got=%b exp=0", irq_a); end
    bus_write(0, 2'd3, 32'h0000_0008);
    exp_q.push_back(32'h0); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL set_wins_clear: got=%h exp=%h", got, exp); end
  endtask

  // Any-edge capture with level irq (second instance).
  task automatic test_any_edge();
    bus_write(1, 2'd2, 32'h0000_0080);
    total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL lvl_irq_high: got=%b exp=1", irq_b); end
    in_b = 8'h00;
    #1;
    for (int t = 0; t < SYNC_LAT; t++) begin
      total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL lvl_irq_hold%0d: got=%b exp=1", t, irq_b); end
      tick();
    end
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL lvl_irq_low: got=%b exp=0", irq_b); end
    tick(2);
    exp_q.push_back(32'h0000_0080); bus_read(1, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL any_fall: got=%h exp=%h", got, exp); end
    bus_write(1, 2'd3, 32'h0000_00FF);
    in_b = 8'h01;
    tick(5);
    exp_q.push_back(32'h0000_0001); bus_read(1, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL any_rise: got=%h exp=%h", got, exp); end
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL lvl_irq_unmasked: got=%b exp=0", irq_b); end
  endtask

  // Reset in the middle of operation clears captures and an in-flight write.
  task automatic test_reset_mid();
    bus_write(0, 2'd2, 32'h0000_00FF);
    in_a = 8'hFF;  // rising bits 0x52 from 0xAD
    tick(5);
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL mid_irq_pre: got=%b exp=1", irq_a); end
    exp_q.push_back(32'h0000_0052); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL mid_edgecap_pre: got=%h exp=%h", got, exp); end
    if_a.address = 2'd3;
    tick();
    if_a.address = 2'd2; if_a.chipselect = 1'b1; if_a.write_n = 1'b0; if_a.writedata = 32'h33;
    reset = 1'b1;
    #1;
    total++; if (if_a.readdata !== 32'h0) begin bad++; $display("FAIL mid_async_readdata: got=%h exp=%h", if_a.readdata, 32'h0); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL mid_async_irq: got=%b exp=0", irq_a); end
    tick();
    bus_idle();
    reset = 1'b0;
    tick(6);
    exp_q.push_back(32'h0); bus_read(0, 2'd2, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL mid_mask: got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0); bus_read(0, 2'd3, got); exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL mid_edgecap: got=%h exp=%h", got, exp); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL mid_irq_post: got=%b exp=0", irq_a); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_data_read();
    test_irq_edge();
    test_set_wins();
    test_any_edge();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
